// File: rtl/location_compare_arbiter.sv
// Round-robin arbiter sharing one roughly_equal_locations comparator among NUM_REQ requesters.
// Define LOC_ARB_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYCLES and report resp_timeout.
module location_compare_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [12*NUM_REQ-1:0] req_loc_1,
  input  logic [12*NUM_REQ-1:0] req_loc_2,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic                  resp_equal,
  output logic                  resp_timeout,
  output logic                  busy,
  output logic                  cmp_enable,
  output logic [11:0]           cmp_loc_1,
  output logic [11:0]           cmp_loc_2,
  input  logic                  cmp_done,
  input  logic                  cmp_equal
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WAIT, RESP} state_t;

  state_t             state;
  state_t             next_state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   gnt_next;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic               blackout;
  logic               eq_r;
  logic               timeout_hit;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [NUM_REQ-1:0] masked_req;
  logic [11:0]        sel_loc_1;
  logic [11:0]        sel_loc_2;
  int                 cand;

  assign resp_equal = eq_r;
  assign gnt_next   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    gnt_onehot = '0;
    sel_loc_1  = '0;
    sel_loc_2  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        gnt_onehot[i] = 1'b1;
        sel_loc_1     = req_loc_1[12*i +: 12];
        sel_loc_2     = req_loc_2[12*i +: 12];
      end
    end
  end

  // The requester just served is masked for one IDLE cycle so a late req drop cannot re-win.
  always_comb begin
    masked_req = req;
    if (blackout) masked_req = req & ~gnt_onehot;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = (int'(rr_ptr) + off) % NUM_REQ;
      if (masked_req[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (win_found) next_state = GRANT;
      GRANT:   next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (cmp_done || timeout_hit) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gnt_idx    <= '0;
      blackout   <= 1'b0;
      eq_r       <= 1'b0;
      resp_valid <= '0;
      busy       <= 1'b0;
      cmp_enable <= 1'b0;
      cmp_loc_1  <= '0;
      cmp_loc_2  <= '0;
    end else begin
      state      <= next_state;
      busy       <= (next_state != IDLE);
      cmp_enable <= (next_state == ISSUE);
      blackout   <= (state == RESP);
      if (state == IDLE && win_found) gnt_idx <= win_idx;
      if (state == GRANT) begin
        cmp_loc_1 <= sel_loc_1;
        cmp_loc_2 <= sel_loc_2;
      end
      // A timeout exit has cmp_done low, which forces the reported result to 0.
      if (state == WAIT && next_state == RESP) begin
        rr_ptr     <= gnt_next;
        resp_valid <= gnt_onehot;
        eq_r       <= cmp_done & cmp_equal;
      end else begin
        resp_valid <= '0;
        eq_r       <= 1'b0;
      end
    end
  end

`ifdef LOC_ARB_TIMEOUT_EN
  logic [3:0] wait_cnt;

  assign timeout_hit = (state == WAIT) && (wait_cnt == 4'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt     <= '0;
      resp_timeout <= 1'b0;
    end else begin
      if (state != WAIT)     wait_cnt <= '0;
      else if (!timeout_hit) wait_cnt <= wait_cnt + 4'd1;
      resp_timeout <= (state == WAIT) && !cmp_done && timeout_hit;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit  = 1'b0;
  assign resp_timeout = 1'b0;
`endif

endmodule
